// File: rtl/prefix_adder_arb_pkg.sv
// Shared definitions for the shared-adder arbiter: FSM encoding and ID width helper.
package prefix_adder_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prefix_adder.sv
// Parallel-prefix (Kogge-Stone) adder: WIDTH-bit sum plus carry-out, LEVELS prefix stages.
module prefix_adder #(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 2**LEVELS
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] g_lvl [LEVELS+1];
    logic [WIDTH-1:0] p_lvl [LEVELS+1];

    // Generate/propagate prefix tree; carry-in is folded into bit 0's generate so
    // every final G[i] is the carry out of bit i.
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            g_lvl[l] = '0;
            p_lvl[l] = '0;
        end
        p_lvl[0]    = a_i ^ b_i;
        g_lvl[0]    = a_i & b_i;
        g_lvl[0][0] = g_lvl[0][0] | (p_lvl[0][0] & cin_i);
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i-(1<<l)]);
                    p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i-(1<<l)];
                end else begin
                    g_lvl[l+1][i] = g_lvl[l][i];
                    p_lvl[l+1][i] = p_lvl[l][i];
                end
            end
        end
        sum_o  = p_lvl[0] ^ {g_lvl[LEVELS][WIDTH-2:0], cin_i};
        cout_o = g_lvl[LEVELS][WIDTH-1];
    end

endmodule

// File: rtl/prefix_adder_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_picker
    import prefix_adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic found;
    int   j;

    // Scan ptr, ptr+1, ... modulo NREQ and stop at the first valid requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!found && valid_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/prefix_adder_arbiter.sv
// Round-robin front end sharing one prefix_adder among NREQ requesters.
//
// state | meaning
// IDLE  | nothing in flight; grant window open
// EXEC  | operands registered, adder evaluating
// RESP  | result held on rsp_*; grant window open only while rsp_ready
module prefix_adder_arbiter
    import prefix_adder_arb_pkg::*;
#(
    parameter int LEVELS = 3,
    parameter int WIDTH  = 2**LEVELS,
    parameter int NREQ   = 4,
    parameter int IDW    = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] opx_q, opy_q;
    logic             opcin_q;
    logic [IDW-1:0]   opid_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic [IDW-1:0]   rsp_id_q;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic             grant_win;
    logic             grant;
    logic             load_rsp;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    prefix_adder #(
        .LEVELS (LEVELS),
        .WIDTH  (WIDTH)
    ) u_adder (
        .a_i    (opx_q),
        .b_i    (opy_q),
        .cin_i  (opcin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Next state, grant window and pointer advance.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_win = 1'b0;
        load_rsp  = 1'b0;
        grant     = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                grant_win = 1'b1;
                if (pick_any) state_d = EXEC;
            end
            EXEC: begin
                load_rsp = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    grant_win = 1'b1;
                    state_d   = pick_any ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        grant = grant_win && pick_any;
        if (grant) begin
            ptr_d = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + IDW'(1);
        end
        // The register bank is already held in reset, so only the visible grant needs gating.
        if (grant_win && !rst) req_ready = pick_gnt;
    end

    // State and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Operand capture on the grant handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opx_q   <= '0;
            opy_q   <= '0;
            opcin_q <= 1'b0;
            opid_q  <= '0;
        end else if (grant) begin
            opx_q   <= req_x[int'(pick_idx)*WIDTH +: WIDTH];
            opy_q   <= req_y[int'(pick_idx)*WIDTH +: WIDTH];
            opcin_q <= req_cin[pick_idx];
            opid_q  <= pick_idx;
        end
    end

    // Response register, loaded at the end of EXEC and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= '0;
        end else if (load_rsp) begin
            rsp_sum_q  <= add_sum;
            rsp_cout_q <= add_cout;
            rsp_id_q   <= opid_q;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_id    = rsp_id_q;

endmodule
